jt12_wrqueue: RTL and testbench

Host-side register-write queue placed directly upstream of the FM/PSG sound core. It buffers CPU bus writes (address-port and data-port) in a FIFO and replays them on the core's bus pins (`din`, `addr`, `cs_n`, `wr_n`). Each strobe spans at least one clock-enable pulse. After every data-port write the queue polls the core's busy flag before issuing the next write, so host software never stalls on the chip's internal write latency.

---
 rtl/jt12_wrqueue_if.sv | 32 +++
 rtl/jt12_wrqueue.sv | 129 ++++++++++++
 tb/tb_jt12_wrqueue.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_wrqueue_if.sv
// Host-side write port and core-side bus pins of the jt12 register-write queue.
// master = CPU/host side, slave = the queue itself.
interface jt12_wrqueue_if #(
   parameter int DEPTH_LOG2 = 3
);
   logic                  host_wr;
   logic [1:0]            host_addr;
   logic [7:0]            host_din;
   logic                  host_full;
   logic                  host_idle;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic                  to_err;
   logic                  clr_err;
   logic [7:0]            ym_din;
   logic [1:0]            ym_addr;
   logic                  ym_cs_n;
   logic                  ym_wr_n;
   logic                  ym_busy;

   modport master (
      output host_wr, host_addr, host_din, clr_err, ym_busy,
      input  host_full, host_idle, level, overflow, to_err,
             ym_din, ym_addr, ym_cs_n, ym_wr_n
   );

   modport slave (
      input  host_wr, host_addr, host_din, clr_err, ym_busy,
      output host_full, host_idle, level, overflow, to_err,
             ym_din, ym_addr, ym_cs_n, ym_wr_n
   );
endinterface

// File: rtl/jt12_wrqueue.sv
// FIFO of CPU register writes replayed onto the jt12 bus; first strobe one clk after the push,
// strobe held until a cen edge, busy polled after data writes; pushes at full are dropped (sticky overflow).
module jt12_wrqueue #(
   parameter int DEPTH_LOG2   = 3,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cen,
   jt12_wrqueue_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STROBE = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   logic [9:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level;
   logic [1:0]            state;
   logic [7:0]            timer;
   logic                  is_data;
   logic                  cs_n;
   logic                  wr_n;
   logic [1:0]            addr;
   logic [7:0]            din;
   logic                  overflow;
   logic                  to_err;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  to_set;
   logic [9:0]            head;

   // full comes from the registered level, so a same-cycle pop never rescues a push at full
   assign full   = (level == FULL_LEVEL);
   assign push   = bus.host_wr && !full;
   assign pop    = (state == ST_IDLE) && (level != '0);
   assign head   = mem[rd_ptr];
   assign to_set = (state == ST_WAIT) && cen && bus.ym_busy && (timer == 8'd1);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.host_addr, bus.host_din};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cs_n    <= 1'b1;
         wr_n    <= 1'b1;
         addr    <= 2'd0;
         din     <= 8'd0;
         is_data <= 1'b0;
         timer   <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: if (pop) begin
               addr    <= head[9:8];
               din     <= head[7:0];
               is_data <= head[8];
               cs_n    <= 1'b0;
               wr_n    <= 1'b0;
               state   <= ST_STROBE;
            end
            ST_STROBE: if (cen) begin
               cs_n    <= 1'b1;
               wr_n    <= 1'b1;
               addr[0] <= 1'b0;   // point the core at its status word while polling busy
               state   <= ST_GAP;
            end
            ST_GAP: if (cen) begin
               if (is_data) begin
                  timer <= 8'(BUSY_TIMEOUT);
                  state <= ST_WAIT;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: if (cen) begin
               if (!bus.ym_busy || timer == 8'd1) state <= ST_IDLE;
               else                               timer <= timer - 8'd1;
            end
         endcase
      end
   end

   // set beats clear when both land on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         to_err   <= 1'b0;
      end else begin
         if (bus.host_wr && full) overflow <= 1'b1;
         else if (bus.clr_err)    overflow <= 1'b0;
         if (to_set)              to_err   <= 1'b1;
         else if (bus.clr_err)    to_err   <= 1'b0;
      end
   end

   assign bus.host_full = full;
   assign bus.host_idle = (level == '0) && (state == ST_IDLE);
   assign bus.level     = level;
   assign bus.overflow  = overflow;
   assign bus.to_err    = to_err;
   assign bus.ym_din    = din;
   assign bus.ym_addr   = addr;
   assign bus.ym_cs_n   = cs_n;
   assign bus.ym_wr_n   = wr_n;
endmodule

// File: tb/tb_jt12_wrqueue.sv
// Scoreboard bench for jt12_wrqueue: stimulus queues expected bus writes, a negedge monitor checks replays.
module tb_jt12_wrqueue;
   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       cen     = 1'b1;
   bit         cen_div = 1'b0;
   logic [1:0] cen_cnt = 2'd0;
   int         vecs    = 0;
   int         errs    = 0;
   logic [9:0] exp_q [$];
   logic [9:0] mon_e;
   logic       prev_wr_n = 1'b1;
   logic       prev_cen  = 1'b1;

   jt12_wrqueue_if #(.DEPTH_LOG2(3)) bus ();

   jt12_wrqueue #(.DEPTH_LOG2(3), .BUSY_TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (cen),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endfunction

   // cen high one cycle in four while cen_div is set
   always @(posedge clk) begin
      if (cen_div) begin
         #1;
         cen_cnt = cen_cnt + 2'd1;
         cen     = (cen_cnt == 2'd0);
      end
   end

   // monitor: strobe start pops the scoreboard, strobe must end exactly on the first cen edge
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_wr_n = 1'b1;
         prev_cen  = cen;
      end else begin
         if (!prev_wr_n) begin
            chk("strobe_width_wr", bus.ym_wr_n, prev_cen);
            chk("strobe_width_cs", bus.ym_cs_n, prev_cen);
         end else if (!bus.ym_wr_n) begin
            if (exp_q.size() == 0) begin
               vecs++;
               errs++;
               $display("FAIL spurious_strobe: got addr %0d din 0x%0h, want no write", bus.ym_addr, bus.ym_din);
            end else begin
               mon_e = exp_q.pop_front();
               chk("replay_addr", bus.ym_addr, mon_e[9:8]);
               chk("replay_din", bus.ym_din, mon_e[7:0]);
               chk("replay_cs", bus.ym_cs_n, 0);
            end
         end
         prev_wr_n = bus.ym_wr_n;
         prev_cen  = cen;
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(logic [1:0] a, logic [7:0] d, bit accept);
      bus.host_wr   = 1'b1;
      bus.host_addr = a;
      bus.host_din  = d;
      if (accept) exp_q.push_back({a, d});
      tick(1);
      bus.host_wr = 1'b0;
   endtask

   task automatic drain(int bound);
      int n = 0;
      while ((exp_q.size() != 0 || !bus.host_idle) && n < bound) begin
         tick(1);
         n++;
      end
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_idle", bus.host_idle, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish before 1 ms");
      $fatal(1);
   end

   initial begin
      bus.host_wr   = 1'b0;
      bus.host_addr = 2'd0;
      bus.host_din  = 8'd0;
      bus.clr_err   = 1'b0;
      bus.ym_busy   = 1'b0;
      #12;
      chk("rst_cs_n", bus.ym_cs_n, 1);
      chk("rst_wr_n", bus.ym_wr_n, 1);
      chk("rst_addr", bus.ym_addr, 0);
      chk("rst_din", bus.ym_din, 0);
      chk("rst_full", bus.host_full, 0);
      chk("rst_idle", bus.host_idle, 1);
      chk("rst_level", bus.level, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_to_err", bus.to_err, 0);
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // address write, cen tied high
      push(2'd0, 8'h28, 1);
      chk("t1_level_after_push", bus.level, 1);
      chk("t1_idle_after_push", bus.host_idle, 0);
      tick(1);
      chk("t1_strobe_low", bus.ym_wr_n, 0);
      chk("t1_level_after_pop", bus.level, 0);
      tick(1);
      chk("t1_strobe_high", bus.ym_wr_n, 1);
      tick(1);
      chk("t1_idle_again", bus.host_idle, 1);

      // address then data write, busy released just before the timeout edge
      bus.ym_busy = 1'b1;
      push(2'd0, 8'h2A, 1);
      push(2'd1, 8'h80, 1);
      tick(3);
      chk("t2_data_strobe", bus.ym_wr_n, 0);
      tick(2);
      chk("t2_addr_in_wait", bus.ym_addr, 0);
      chk("t2_din_in_wait", bus.ym_din, 8'h80);
      chk("t2_busy_in_wait", bus.host_idle, 0);
      tick(3);
      chk("t2_still_waiting", bus.host_idle, 0);
      bus.ym_busy = 1'b0;
      tick(1);
      chk("t2_left_wait", bus.host_idle, 1);
      chk("t2_no_to_err", bus.to_err, 0);

      // busy stuck: timeout after 4 cen pulses, next entry still issued
      bus.ym_busy = 1'b1;
      push(2'd1, 8'h55, 1);
      push(2'd0, 8'h66, 1);
      tick(5);
      chk("t3_to_err_early", bus.to_err, 0);
      chk("t3_still_waiting", bus.host_idle, 0);
      tick(1);
      chk("t3_to_err_set", bus.to_err, 1);
      tick(1);
      chk("t3_next_strobe", bus.ym_wr_n, 0);
      bus.clr_err = 1'b1;
      tick(1);
      bus.clr_err = 1'b0;
      chk("t3_to_err_clr", bus.to_err, 0);
      bus.ym_busy = 1'b0;
      tick(2);
      chk("t3_idle", bus.host_idle, 1);

      // overflow: freeze the FSM in WAIT with cen low, push 9 entries
      bus.ym_busy = 1'b1;
      push(2'd1, 8'h90, 1);
      tick(3);
      cen = 1'b0;
      for (int i = 1; i <= 9; i++) push(2'd0, 8'(i), i <= 8);
      chk("t4_level_full", bus.level, 8);
      chk("t4_full", bus.host_full, 1);
      chk("t4_overflow", bus.overflow, 1);
      bus.clr_err = 1'b1;
      tick(1);
      bus.clr_err = 1'b0;
      chk("t4_overflow_clr", bus.overflow, 0);
      chk("t4_level_held", bus.level, 8);
      bus.ym_busy = 1'b0;
      cen = 1'b1;
      drain(400);

      // cen one in four, 20 entries across pointer wrap
      cen_div = 1'b1;
      for (int i = 0; i < 20; i++) begin
         int g = 0;
         while (bus.host_full && g < 500) begin
            tick(1);
            g++;
         end
         chk("t5_not_full", bus.host_full, 0);
         push(2'(i), 8'(8'hA0 + i), 1);
      end
      cen_div = 1'b0;
      tick(1);
      cen = 1'b1;
      drain(3000);

      // asynchronous reset in the middle of a held strobe
      cen = 1'b0;
      push(2'd0, 8'h11, 1);
      push(2'd0, 8'h22, 1);
      push(2'd0, 8'h33, 1);
      chk("t6_strobe_held", bus.ym_wr_n, 0);
      chk("t6_level", bus.level, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_wr_n", bus.ym_wr_n, 1);
      chk("t6_async_cs_n", bus.ym_cs_n, 1);
      chk("t6_async_level", bus.level, 0);
      chk("t6_async_idle", bus.host_idle, 1);
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      cen   = 1'b1;
      tick(6);
      chk("t6_idle_after", bus.host_idle, 1);
      chk("t6_level_after", bus.level, 0);
      chk("t6_no_replay", bus.ym_wr_n, 1);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
